// File: rtl/regfile_pkg.sv
// Shared widths, write-request type and register-zero constant for the register-file
// write path.
package regfile_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 6;

  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } rf_wr_req_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Signal bundle between the pipeline / mul-div unit and the register-file write arbiter.
// The master side is the pipeline; the slave side is the arbiter.
interface regfile_write_arbiter_if;
  import regfile_pkg::*;

  logic                  wbValid;
  logic [ADDR_WIDTH-1:0] wbAddr;
  logic [DATA_WIDTH-1:0] wbData;
  logic                  mdIssue;
  logic [ADDR_WIDTH-1:0] mdIssueAddr;
  logic                  mdValid;
  logic                  mdReady;
  logic [ADDR_WIDTH-1:0] mdAddr;
  logic [DATA_WIDTH-1:0] mdData;
  logic [ADDR_WIDTH-1:0] idSrc1;
  logic [ADDR_WIDTH-1:0] idSrc2;
  logic [ADDR_WIDTH-1:0] idDest;
  logic                  idDestValid;
  logic                  hazardStall;
  logic                  starveStall;
  logic                  writeEn;
  logic [ADDR_WIDTH-1:0] writeAddr;
  logic [DATA_WIDTH-1:0] writeData;

  modport master (
    output wbValid, wbAddr, wbData, mdIssue, mdIssueAddr, mdValid, mdAddr, mdData,
           idSrc1, idSrc2, idDest, idDestValid,
    input  mdReady, hazardStall, starveStall, writeEn, writeAddr, writeData
  );

  modport slave (
    input  wbValid, wbAddr, wbData, mdIssue, mdIssueAddr, mdValid, mdAddr, mdData,
           idSrc1, idSrc2, idDest, idDestValid,
    output mdReady, hazardStall, starveStall, writeEn, writeAddr, writeData
  );
endinterface

// File: rtl/wb_queue.sv
// Small synchronous FIFO of pending mul/div register writes. The caller guarantees
// push only when not full and pop only when not empty.
module wb_queue
  import regfile_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  rf_wr_req_t pushReq,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output rf_wr_req_t head
);
  localparam int PW = $clog2(QDEPTH);

  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [PW:0]   count;
  rf_wr_req_t    mem [QDEPTH];

  // Pointers are PW bits wide, so a power-of-2 depth wraps them for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= pushReq;
  end

  assign full  = (count == (PW+1)'(QDEPTH));
  assign empty = (count == '0);
  assign head  = mem[rdPtr];
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single RegisterFile write port between writeback (fixed priority) and a
// queued mul/div result stream; tracks in-flight mul/div destinations for decode hazards.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int QDEPTH       = 2,
  parameter int STARVE_LIMIT = 8
) (
  input logic                    clk,
  input logic                    rst,
  regfile_write_arbiter_if.slave bus
);
  localparam int NREG = 2 ** ADDR_WIDTH;
  localparam int CW   = $clog2(STARVE_LIMIT + 1);

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  rf_wr_req_t      head;
  rf_wr_req_t      mdReq;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] setMask;
  logic [NREG-1:0] clrMask;
  logic [CW-1:0]   starveCnt;

  // Ready is held low during reset and never sees a same-cycle pop (no push-through).
  assign bus.mdReady = ~rst & ~full;
  assign push        = bus.mdValid & bus.mdReady;
  assign pop         = ~rst & ~bus.wbValid & ~empty;
  assign mdReq       = '{addr: bus.mdAddr, data: bus.mdData};

  wb_queue #(.QDEPTH(QDEPTH)) uQueue (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pushReq (mdReq),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  // Register zero requests are consumed but never reach the register file.
  always_comb begin
    bus.writeEn   = 1'b0;
    bus.writeAddr = '0;
    bus.writeData = '0;
    if (!rst) begin
      if (bus.wbValid) begin
        if (bus.wbAddr != REG_ZERO) begin
          bus.writeEn   = 1'b1;
          bus.writeAddr = bus.wbAddr;
          bus.writeData = bus.wbData;
        end
      end else if (!empty && head.addr != REG_ZERO) begin
        bus.writeEn   = 1'b1;
        bus.writeAddr = head.addr;
        bus.writeData = head.data;
      end
    end
  end

  // Set after clear so a same-cycle commit and re-issue leaves the register pending.
  always_comb begin
    setMask = '0;
    clrMask = '0;
    if (pop) clrMask[head.addr] = 1'b1;
    if (bus.mdIssue && bus.mdIssueAddr != REG_ZERO) setMask[bus.mdIssueAddr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clrMask) | setMask;
  end

  assign bus.hazardStall = pending[bus.idSrc1] | pending[bus.idSrc2] |
                           (bus.idDestValid & pending[bus.idDest]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starveCnt <= '0;
    end else if (empty || pop) begin
      starveCnt <= '0;
    end else if (bus.wbValid && starveCnt != CW'(STARVE_LIMIT)) begin
      starveCnt <= starveCnt + 1'b1;
    end
  end

  assign bus.starveStall = (starveCnt >= CW'(STARVE_LIMIT));
endmodule
